// File: rtl/nibble_serial_adder_ctrl_pkg.sv
// rtl/nibble_serial_adder_ctrl_pkg.sv - shared types and constants for the nibble-serial adder
package nibble_serial_adder_ctrl_pkg;

    localparam int NIBBLE_W = 4;

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_RUN  = 2'd1,
        S_DONE = 2'd2
    } state_t;

    function automatic bit width_ok(input int w);
        return (w >= NIBBLE_W) && ((w % NIBBLE_W) == 0);
    endfunction

endpackage

// File: rtl/nibble_serial_adder_ctrl_nibble_adder4.sv
// rtl/nibble_serial_adder_ctrl_nibble_adder4.sv - combinational 4-bit ripple-carry adder
module nibble_adder4
    import nibble_serial_adder_ctrl_pkg::*;
(
    output logic [NIBBLE_W-1:0] s,
    output logic                co,
    input  logic [NIBBLE_W-1:0] x,
    input  logic [NIBBLE_W-1:0] y,
    input  logic                ci
);

    logic [NIBBLE_W:0] c;

    always_comb begin
        c    = '0;
        s    = '0;
        c[0] = ci;
        for (int i = 0; i < NIBBLE_W; i++) begin
            s[i]   = x[i] ^ y[i] ^ c[i];
            c[i+1] = (x[i] & y[i]) | (x[i] & c[i]) | (y[i] & c[i]);
        end
    end

    assign co = c[NIBBLE_W];

endmodule

// File: rtl/nibble_serial_adder_ctrl.sv
// rtl/nibble_serial_adder_ctrl.sv - WIDTH-bit add/sub sequenced over one shared nibble adder
module nibble_serial_adder_ctrl
    import nibble_serial_adder_ctrl_pkg::*;
#(
    parameter int WIDTH = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             cin,
    input  logic             sub,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] sum,
    output logic             cout,
    output logic             ovf,
    output logic             busy
);

    localparam int NIB   = WIDTH / NIBBLE_W;
    localparam int IDX_W = (NIB > 1) ? $clog2(NIB) : 1;
    localparam int MSB   = WIDTH - 1;
    localparam logic [IDX_W-1:0] LAST = IDX_W'(NIB - 1);

    generate
        if (!width_ok(WIDTH)) begin : g_width_check
            $error("nibble_serial_adder_ctrl: WIDTH must be a multiple of 4 and >= 4");
        end
    endgenerate

    state_t             state;
    logic [IDX_W-1:0]   idx;
    logic               carry;
    logic [WIDTH-1:0]   a_r;
    logic [WIDTH-1:0]   b_r;
    logic [WIDTH-1:0]   work;
    logic [WIDTH-1:0]   work_next;
    logic [IDX_W+1:0]   bit_base;
    logic [NIBBLE_W-1:0] nib_s;
    logic               nib_co;
    logic               ovf_next;

    assign bit_base = {idx, 2'b00};

    nibble_adder4 u_adder (
        .s  (nib_s),
        .co (nib_co),
        .x  (a_r[bit_base +: NIBBLE_W]),
        .y  (b_r[bit_base +: NIBBLE_W]),
        .ci (carry)
    );

    // b_r already holds ~b for subtract, so the sign rule uses the effective operand
    always_comb begin
        work_next = work;
        work_next[bit_base +: NIBBLE_W] = nib_s;
        ovf_next = (a_r[MSB] == b_r[MSB]) && (work_next[MSB] != a_r[MSB]);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= S_IDLE;
            idx       <= '0;
            carry     <= 1'b0;
            a_r       <= '0;
            b_r       <= '0;
            work      <= '0;
            sum       <= '0;
            cout      <= 1'b0;
            ovf       <= 1'b0;
            out_valid <= 1'b0;
            busy      <= 1'b0;
            in_ready  <= 1'b1;
        end else begin
            case (state)
                S_IDLE: begin
                    if (in_valid) begin
                        a_r      <= a;
                        b_r      <= sub ? ~b : b;
                        carry    <= sub | cin;
                        idx      <= '0;
                        in_ready <= 1'b0;
                        busy     <= 1'b1;
                        state    <= S_RUN;
                    end
                end
                S_RUN: begin
                    work  <= work_next;
                    carry <= nib_co;
                    idx   <= idx + 1'b1;
                    if (idx == LAST) begin
                        sum       <= work_next;
                        cout      <= nib_co;
                        ovf       <= ovf_next;
                        out_valid <= 1'b1;
                        idx       <= '0;
                        state     <= S_DONE;
                    end
                end
                S_DONE: begin
                    if (out_ready) begin
                        out_valid <= 1'b0;
                        busy      <= 1'b0;
                        in_ready  <= 1'b1;
                        state     <= S_IDLE;
                    end
                end
                default: state <= S_IDLE;
            endcase
        end
    end

endmodule

// File: doc/nibble_serial_adder_ctrl.md
Name: nibble_serial_adder_ctrl

Overview:
Sequencer that performs WIDTH-bit add/subtract by time-multiplexing a single 4-bit ripple-carry adder, one nibble per clock, LSB nibble first. It holds the inter-nibble carry in a register and wraps the operation in valid/ready handshakes on both sides. It trades latency for area in wide-operand arithmetic paths.

Parameters:
WIDTH, 16, operand/result width in bits; must be a multiple of 4 and >= 4 (elaboration error otherwise)
NIB, WIDTH/4, derived localparam, number of nibble cycles per operation

Ports:
clk  input  1  clock, all logic on rising edge
rst  input  1  synchronous, active-high reset
in_valid  input  1  operand request valid
in_ready  output  1  block can accept an operation
a  input  WIDTH  operand A
b  input  WIDTH  operand B
cin  input  1  carry-in, used only when sub=0
sub  input  1  1 = A - B, 0 = A + B + cin
out_valid  output  1  result valid
out_ready  input  1  downstream accepts result
sum  output  WIDTH  result
cout  output  1  carry-out of MSB nibble; for sub, 1 = no borrow
ovf  output  1  two's-complement signed overflow
busy  output  1  high in RUN or DONE

Behaviour:
- Reset (rst=1 at a clock edge): state=IDLE, nibble index=0, carry reg=0, sum=0, cout=0, ovf=0, out_valid=0, busy=0, in_ready=1 from the first cycle after reset.
- rst has priority over every other event. Reset mid-RUN or mid-DONE discards the operation and produces no out_valid.
- FSM states: IDLE, RUN, DONE.
- IDLE:
  - in_ready=1.
  - On in_valid&&in_ready, capture a and b_eff (b_eff = sub ? ~b : b). Set carry reg to (sub ? 1 : cin). Capture sub for the ovf calculation. Go to RUN with index=0.
- RUN:
  - in_ready=0.
  - Each cycle, the adder sums nibble[index] of a, nibble[index] of b_eff, and the carry reg.
  - The 4-bit result is written into the working result register at nibble[index]. The adder carry-out goes to the carry reg.
  - index increments. Exactly NIB cycles are spent in RUN.
  - On the last nibble (index=NIB-1):
    - Transfer the working result to sum.
    - cout = final carry.
    - ovf = (a[MSB]==b_eff[MSB]) && (sum[MSB]!=a[MSB]).
    - Go to DONE.
- DONE:
  - out_valid=1. sum/cout/ovf are stable.
  - in_ready=0; in_valid is ignored.
  - On out_ready=1, go to IDLE; out_valid drops the next cycle.
  - out_ready held low holds DONE indefinitely.
- Latency: accept edge at cycle T gives out_valid=1 during cycle T+NIB+1. Minimum issue interval is NIB+2 cycles.
- Output holding: sum/cout/ovf change only at the RUN→DONE transition or reset. They hold the last result while in IDLE/RUN. They are meaningful only when out_valid=1.
- Width rules:
  - All arithmetic is modulo 2^WIDTH.
  - No inter-nibble carry is lost.
  - The index counter is $clog2(NIB) bits, minimum 1 bit.
  - For WIDTH=4, RUN lasts one cycle.
- out_ready asserted outside DONE has no effect.

Decomposition:
- Shared package: FSM state encoding (IDLE/RUN/DONE), NIBBLE_W=4 constant, a width-check macro/function for WIDTH%4.
- One sub-module: nibble_adder4.
  - Ports: s[3:0], co, x[3:0], y[3:0], ci.
  - Purely combinational 4-bit ripple-carry adder, built from per-bit sum = x^y^ci and carry = majority.
  - Instantiated once; the controller owns all registers.

Test Plan (WIDTH=16, NIB=4):
- Reset: hold rst 3 cycles with in_valid=1 → all outputs 0, busy=0; in_ready=1 on the first cycle after release.
- Add: a=0x1234, b=0x4321, cin=0, sub=0 accepted at cycle T → out_valid first high at T+5, sum=0x5555, cout=0, ovf=0.
- Full ripple: a=0xFFFF, b=0x0000, cin=1 → sum=0x0000, cout=1, ovf=0. Also a=0x7FFF, b=0x0001, cin=0 → sum=0x8000, cout=0, ovf=1.
- Subtract: a=0x0005, b=0x0007, sub=1, cin=1 (cin ignored) → sum=0xFFFE, cout=0, ovf=0. Also a=0x8000, b=0x0001, sub=1 → sum=0x7FFF, cout=1, ovf=1.
- Backpressure: hold out_ready=0 for 3 cycles in DONE while toggling in_valid and a/b → outputs stable, in_ready=0, no capture. Then out_ready=1 → IDLE next cycle, and a new op accepted and correct.
- Reset mid-op: assert rst in the 2nd RUN cycle → IDLE next cycle, out_valid never asserted, sum unchanged at 0. The following op 0x00FF+0x0001 → 0x0100, cout=0, ovf=0.
